// File: rtl/writeback_if.sv
// Bundle of execute-result, decode-query and register-file write signals for writeback_unit.
// master = execute/decode side, slave = writeback_unit.
interface writeback_if #(
  parameter int unsigned XLEN = 32
);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            mdu_valid;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_data;
  logic            mdu_ready;

  logic            issue_valid;
  logic            issue_long;
  logic [4:0]      issue_rd;

  logic [4:0]      query_rs1;
  logic [4:0]      query_rs2;
  logic            stall_rs1;
  logic            stall_rs2;
  logic            fwd_valid_1;
  logic            fwd_valid_2;
  logic [XLEN-1:0] fwd_data_1;
  logic [XLEN-1:0] fwd_data_2;

  logic [31:0]     rf_write_address;
  logic [XLEN-1:0] rf_write_data;
  logic            rf_write_enable;
  logic            wb_error;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready,
    output issue_valid, issue_long, issue_rd,
    output query_rs1, query_rs2,
    input  stall_rs1, stall_rs2, fwd_valid_1, fwd_valid_2, fwd_data_1, fwd_data_2,
    input  rf_write_address, rf_write_data, rf_write_enable, wb_error
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mdu_valid, mdu_rd, mdu_data,
    output mdu_ready,
    input  issue_valid, issue_long, issue_rd,
    input  query_rs1, query_rs2,
    output stall_rs1, stall_rs2, fwd_valid_1, fwd_valid_2, fwd_data_1, fwd_data_2,
    output rf_write_address, rf_write_data, rf_write_enable, wb_error
  );
endinterface

// File: rtl/writeback_unit.sv
// Register-file write port arbiter (ALU first, then queued MDU results) with pending-write
// scoreboard for decode hazards. Define WB_FORWARD_EN to bypass the in-flight write to decode.
module writeback_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  writeback_if.slave        io_bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [4:0]      r_fifo_rd   [FIFO_DEPTH];
  logic [XLEN-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;

  logic [31:0]     r_pending;
  logic            r_we;
  logic            r_we_mdu;
  logic [4:0]      r_addr;
  logic [XLEN-1:0] r_data;
  logic            r_error;

  logic            w_full;
  logic            w_empty;
  logic            w_mdu_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_sel_alu;
  logic            w_issue_set;
  logic [4:0]      w_head_rd;
  logic [XLEN-1:0] w_head_data;
  logic            w_we_d;
  logic            w_we_mdu_d;
  logic [4:0]      w_addr_d;
  logic [XLEN-1:0] w_data_d;
  logic [31:0]     w_pending_d;
  logic            w_err_d;

  assign w_full      = (r_count == CntW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_mdu_ready = !i_rst && !w_full;
  assign w_push      = io_bus.mdu_valid && w_mdu_ready;
  assign w_sel_alu   = io_bus.alu_valid && (io_bus.alu_rd != 5'd0);
  assign w_pop       = !w_sel_alu && !w_empty;
  assign w_issue_set = io_bus.issue_valid && io_bus.issue_long && (io_bus.issue_rd != 5'd0);
  assign w_head_rd   = r_fifo_rd[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];

  // Popped MDU results for x0 consume a slot but never strobe the port.
  always_comb begin
    w_we_d     = 1'b0;
    w_we_mdu_d = 1'b0;
    w_addr_d   = r_addr;
    w_data_d   = r_data;
    if (w_sel_alu) begin
      w_we_d   = 1'b1;
      w_addr_d = io_bus.alu_rd;
      w_data_d = io_bus.alu_data;
    end else if (w_pop && (w_head_rd != 5'd0)) begin
      w_we_d     = 1'b1;
      w_we_mdu_d = 1'b1;
      w_addr_d   = w_head_rd;
      w_data_d   = w_head_data;
    end
  end

  // Clear first so a same-edge re-issue of the retiring rd keeps it pending.
  always_comb begin
    w_pending_d = r_pending;
    if (r_we && r_we_mdu) begin
      w_pending_d[r_addr] = 1'b0;
    end
    if (w_issue_set) begin
      w_pending_d[io_bus.issue_rd] = 1'b1;
    end
    w_pending_d[0] = 1'b0;
  end

  always_comb begin
    w_err_d = r_error;
    if (w_sel_alu && r_pending[io_bus.alu_rd]) begin
      w_err_d = 1'b1;
    end
    if (w_issue_set && r_pending[io_bus.issue_rd]) begin
      w_err_d = 1'b1;
    end
    if (w_push && (io_bus.mdu_rd != 5'd0) && !r_pending[io_bus.mdu_rd]) begin
      w_err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= io_bus.mdu_rd;
      r_fifo_data[r_wptr] <= io_bus.mdu_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_pending <= '0;
      r_we      <= 1'b0;
      r_we_mdu  <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_error   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      r_count   <= r_count + CntW'(w_push) - CntW'(w_pop);
      r_pending <= w_pending_d;
      r_we      <= w_we_d;
      r_we_mdu  <= w_we_mdu_d;
      r_addr    <= w_addr_d;
      r_data    <= w_data_d;
      r_error   <= w_err_d;
    end
  end

  always_comb begin
    io_bus.stall_rs1   = r_pending[io_bus.query_rs1];
    io_bus.stall_rs2   = r_pending[io_bus.query_rs2];
    io_bus.fwd_valid_1 = 1'b0;
    io_bus.fwd_valid_2 = 1'b0;
    io_bus.fwd_data_1  = '0;
    io_bus.fwd_data_2  = '0;
`ifdef WB_FORWARD_EN
    if (r_we && (r_addr == io_bus.query_rs1) && (io_bus.query_rs1 != 5'd0)) begin
      io_bus.fwd_valid_1 = 1'b1;
      io_bus.fwd_data_1  = r_data;
      io_bus.stall_rs1   = 1'b0;
    end
    if (r_we && (r_addr == io_bus.query_rs2) && (io_bus.query_rs2 != 5'd0)) begin
      io_bus.fwd_valid_2 = 1'b1;
      io_bus.fwd_data_2  = r_data;
      io_bus.stall_rs2   = 1'b0;
    end
`endif
  end

  assign io_bus.mdu_ready        = w_mdu_ready;
  assign io_bus.rf_write_address = {27'd0, r_addr};
  assign io_bus.rf_write_data    = r_data;
  assign io_bus.rf_write_enable  = r_we;
  assign io_bus.wb_error         = r_error;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: queue/array reference model compared every cycle,
// directed scenarios with literal expectations, legal and unconstrained random traffic.
module tb_writeback_unit;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
`ifdef WB_FORWARD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_if #(.XLEN(XLEN)) bus ();

  writeback_unit #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  // Reference model state: what the write port / scoreboard must hold now.
  res_t        m_q[$];
  logic [31:0] m_pend   = '0;
  logic        m_we     = 1'b0;
  logic        m_src    = 1'b0;
  logic        m_err    = 1'b0;
  logic [4:0]  m_addr   = '0;
  logic [31:0] m_data   = '0;
  logic        m_pushed = 1'b0;
  logic        chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic hit(input logic [4:0] q);
    return m_we && (m_addr == q) && (q != 5'd0);
  endfunction

  function automatic logic exp_stall(input logic [4:0] q);
    return (q != 5'd0) && m_pend[q] && !(Fwd && hit(q));
  endfunction

  function automatic logic [31:0] exp_fwd_data(input logic [4:0] q);
    return (Fwd && hit(q)) ? m_data : 32'd0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rf_write_enable", {31'd0, bus.rf_write_enable}, {31'd0, m_we});
      chk("rf_write_address", bus.rf_write_address, {27'd0, m_addr});
      chk("rf_write_data", bus.rf_write_data, m_data);
      chk("wb_error", {31'd0, bus.wb_error}, {31'd0, m_err});
      chk("mdu_ready", {31'd0, bus.mdu_ready},
          {31'd0, (!rst && (m_q.size() < DEPTH))});
      chk("stall_rs1", {31'd0, bus.stall_rs1}, {31'd0, exp_stall(bus.query_rs1)});
      chk("stall_rs2", {31'd0, bus.stall_rs2}, {31'd0, exp_stall(bus.query_rs2)});
      chk("fwd_valid_1", {31'd0, bus.fwd_valid_1}, {31'd0, Fwd && hit(bus.query_rs1)});
      chk("fwd_valid_2", {31'd0, bus.fwd_valid_2}, {31'd0, Fwd && hit(bus.query_rs2)});
      chk("fwd_data_1", bus.fwd_data_1, exp_fwd_data(bus.query_rs1));
      chk("fwd_data_2", bus.fwd_data_2, exp_fwd_data(bus.query_rs2));
    end
  end

  // Advance the model by one clock using the inputs currently applied, then cross the edge.
  task automatic step();
    res_t        n_q[$];
    res_t        e;
    logic [31:0] n_pend;
    logic        n_we;
    logic        n_src;
    logic        n_err;
    logic [4:0]  n_addr;
    logic [31:0] n_data;
    logic        pushed;
    logic        issue;
    n_q = m_q;
    if (rst) begin
      n_q.delete();
      n_pend = '0;
      n_we   = 1'b0;
      n_src  = 1'b0;
      n_err  = 1'b0;
      n_addr = '0;
      n_data = '0;
      pushed = 1'b0;
    end else begin
      pushed = bus.mdu_valid && (m_q.size() < DEPTH);
      issue  = bus.issue_valid && bus.issue_long && (bus.issue_rd != 5'd0);
      n_err  = m_err;
      if (bus.alu_valid && (bus.alu_rd != 5'd0) && m_pend[bus.alu_rd]) n_err = 1'b1;
      if (issue && m_pend[bus.issue_rd]) n_err = 1'b1;
      if (pushed && (bus.mdu_rd != 5'd0) && !m_pend[bus.mdu_rd]) n_err = 1'b1;
      n_we   = 1'b0;
      n_src  = 1'b0;
      n_addr = m_addr;
      n_data = m_data;
      if (bus.alu_valid && (bus.alu_rd != 5'd0)) begin
        n_we   = 1'b1;
        n_addr = bus.alu_rd;
        n_data = bus.alu_data;
      end else if (n_q.size() > 0) begin
        e = n_q.pop_front();
        if (e.rd != 5'd0) begin
          n_we   = 1'b1;
          n_src  = 1'b1;
          n_addr = e.rd;
          n_data = e.data;
        end
      end
      if (pushed) n_q.push_back({bus.mdu_rd, bus.mdu_data});
      n_pend = m_pend;
      if (m_we && m_src) n_pend[m_addr] = 1'b0;
      if (issue) n_pend[bus.issue_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
    m_q      = n_q;
    m_pend   = n_pend;
    m_we     = n_we;
    m_src    = n_src;
    m_err    = n_err;
    m_addr   = n_addr;
    m_data   = n_data;
    m_pushed = pushed;
  endtask

  task automatic idle();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.mdu_valid   = 1'b0;
    bus.mdu_rd      = '0;
    bus.mdu_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_long  = 1'b0;
    bus.issue_rd    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  logic [4:0] outst[$];
  logic [4:0] rd;
  bit         presenting;
  bit         issued;

  initial begin
    rst           = 1'b1;
    idle();
    bus.query_rs1 = '0;
    bus.query_rs2 = '0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("reset_we", {31'd0, bus.rf_write_enable}, 32'd0);
    chk("reset_ready_after", {31'd0, bus.mdu_ready}, 32'd1);

    // ALU write to x5 appears on the port for exactly one cycle.
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'hDEADBEEF;
    step();
    idle();
    chk("alu_we", {31'd0, bus.rf_write_enable}, 32'd1);
    chk("alu_addr", bus.rf_write_address, 32'd5);
    chk("alu_data", bus.rf_write_data, 32'hDEADBEEF);
    step();
    chk("alu_we_drop", {31'd0, bus.rf_write_enable}, 32'd0);

    // Long op to x7; its result waits behind three ALU writes.
    bus.issue_valid = 1'b1;
    bus.issue_long  = 1'b1;
    bus.issue_rd    = 5'd7;
    step();
    idle();
    bus.query_rs1 = 5'd7;
    bus.query_rs2 = 5'd7;
    #1;
    chk("stall7_pending", {31'd0, bus.stall_rs1}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'(i + 1);
      bus.alu_data  = 32'(i + 100);
      bus.mdu_valid = (i == 0);
      bus.mdu_rd    = 5'd7;
      bus.mdu_data  = 32'h1234;
      step();
    end
    idle();
    step();
    chk("mdu7_we", {31'd0, bus.rf_write_enable}, 32'd1);
    chk("mdu7_addr", bus.rf_write_address, 32'd7);
    chk("mdu7_data", bus.rf_write_data, 32'h1234);
`ifdef WB_FORWARD_EN
    chk("fwd7_valid", {31'd0, bus.fwd_valid_2}, 32'd1);
    chk("fwd7_data", bus.fwd_data_2, 32'h1234);
    chk("fwd7_stall", {31'd0, bus.stall_rs2}, 32'd0);
`else
    chk("stall7_wbcycle", {31'd0, bus.stall_rs1}, 32'd1);
`endif
    step();
    chk("stall7_cleared", {31'd0, bus.stall_rs1}, 32'd0);

    // Fill the queue while the ALU owns the port, then drain in order.
    for (int i = 0; i < 4; i++) begin
      bus.issue_valid = 1'b1;
      bus.issue_long  = 1'b1;
      bus.issue_rd    = 5'(10 + i);
      step();
    end
    idle();
    for (int i = 0; i < 5; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd1;
      bus.alu_data  = 32'(i);
      bus.mdu_valid = (i < 4);
      bus.mdu_rd    = 5'(10 + i);
      bus.mdu_data  = 32'hA000 + 32'(i);
      if (i == 4) begin
        #1;
        chk("full_ready", {31'd0, bus.mdu_ready}, 32'd0);
      end
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_addr", bus.rf_write_address, 32'(10 + i));
      chk("drain_data", bus.rf_write_data, 32'hA000 + 32'(i));
      if (i == 0) chk("drain_ready", {31'd0, bus.mdu_ready}, 32'd1);
    end

    // Legal random traffic: no ALU write or long issue to a pending rd.
    outst.delete();
    presenting = 1'b0;
    for (int c = 0; c < 700; c++) begin
      bus.query_rs1   = 5'($urandom_range(0, 31));
      bus.query_rs2   = 5'($urandom_range(0, 31));
      bus.issue_valid = 1'b0;
      bus.issue_long  = 1'b0;
      issued          = 1'b0;
      rd              = 5'($urandom_range(1, 31));
      if (($urandom_range(0, 3) == 0) && !m_pend[rd] && !(rd inside {outst})) begin
        bus.issue_valid = 1'b1;
        bus.issue_long  = 1'b1;
        bus.issue_rd    = rd;
        issued          = 1'b1;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'($urandom_range(0, 31));
      end
      bus.alu_valid = ($urandom_range(0, 1) == 1);
      bus.alu_rd    = 5'($urandom_range(0, 31));
      if (m_pend[bus.alu_rd]) bus.alu_rd = 5'd0;
      bus.alu_data  = $urandom;
      if (!presenting && (outst.size() > 0) && ($urandom_range(0, 1) == 1)) begin
        presenting    = 1'b1;
        bus.mdu_valid = 1'b1;
        bus.mdu_rd    = outst[0];
        bus.mdu_data  = $urandom;
      end
      step();
      if (m_pushed) begin
        void'(outst.pop_front());
        presenting    = 1'b0;
        bus.mdu_valid = 1'b0;
      end
      if (issued) outst.push_back(rd);
    end
    idle();
    chk("legal_no_error", {31'd0, bus.wb_error}, 32'd0);

    // Unconstrained traffic with occasional resets.
    for (int c = 0; c < 300; c++) begin
      rst             = ($urandom_range(0, 49) == 0);
      bus.alu_valid   = ($urandom_range(0, 2) == 0);
      bus.alu_rd      = 5'($urandom_range(0, 31));
      bus.alu_data    = $urandom;
      bus.mdu_valid   = ($urandom_range(0, 1) == 1);
      bus.mdu_rd      = 5'($urandom_range(0, 31));
      bus.mdu_data    = $urandom;
      bus.issue_valid = ($urandom_range(0, 1) == 1);
      bus.issue_long  = ($urandom_range(0, 1) == 1);
      bus.issue_rd    = 5'($urandom_range(0, 31));
      bus.query_rs1   = 5'($urandom_range(0, 31));
      bus.query_rs2   = 5'($urandom_range(0, 31));
      step();
    end

    // x0 writes are dropped; double long issue latches the error until reset.
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'h5555;
    bus.mdu_valid = 1'b1;
    bus.mdu_rd    = 5'd0;
    bus.mdu_data  = 32'h6666;
    step();
    idle();
    chk("x0_we_a", {31'd0, bus.rf_write_enable}, 32'd0);
    step();
    chk("x0_we_b", {31'd0, bus.rf_write_enable}, 32'd0);
    chk("x0_no_error", {31'd0, bus.wb_error}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      bus.issue_valid = 1'b1;
      bus.issue_long  = 1'b1;
      bus.issue_rd    = 5'd3;
      step();
    end
    idle();
    chk("dup_issue_err", {31'd0, bus.wb_error}, 32'd1);
    for (int i = 0; i < 3; i++) step();
    chk("err_sticky", {31'd0, bus.wb_error}, 32'd1);
    do_reset();
    chk("err_cleared", {31'd0, bus.wb_error}, 32'd0);
    step();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
